mc_tag_ctrl: RTL and testbench
==============================

Name: mc_tag_ctrl

Overview:
- Client-side controller for the cache tag memory.
- Drives the tag RAM read/write ports and sequences power-up clear, tag lookup with hit/miss compare, line fill, invalidate and clean.
- Sits between the cache core FSM and the tag RAM.
- Handles one request at a time: valid/ready request, valid/ready response.

Parameters:
- IDX_WIDTH, 8, cache line index width; 2^IDX_WIDTH lines.
- TAG_WIDTH, 12, tag width.
- AGE_WIDTH, 2, age field width.
- STAT_WIDTH, 16, width of optional hit/miss counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid & ready.
- req_op  in  2  0=LOOKUP, 1=FILL, 2=INVALIDATE, 3=CLEAN.
- req_idx  in  IDX_WIDTH  line index.
- req_tag  in  TAG_WIDTH  tag; used by LOOKUP and FILL.
- req_dirty  in  1  LOOKUP: mark dirty on hit. FILL: initial dirty value.
- resp_valid  out  1  LOOKUP result valid; held until resp_ready.
- resp_ready  in  1  response consumed.
- resp_hit  out  1  stored valid and tag match.
- resp_dirty  out  1  stored dirty bit, pre-update.
- resp_valid_line  out  1  stored valid bit, pre-update.
- resp_tag  out  TAG_WIDTH  stored tag, i.e. the victim tag on a miss.
- resp_age  out  AGE_WIDTH  stored age, pre-update.
- init_done  out  1  power-up clear complete.
- Tag RAM write: tr_w_idx (IDX_WIDTH), tr_w_ena, tr_w_valid_we, tr_w_valid, tr_w_dirty_we, tr_w_dirty, tr_w_age_we, tr_w_age (AGE_WIDTH), tr_w_tag_we, tr_w_tag (TAG_WIDTH); all out.
- Tag RAM read: tr_r_idx out IDX_WIDTH, tr_r_ena out 1.
- Tag RAM read data: tr_r_valid, tr_r_dirty, tr_r_age (AGE_WIDTH), tr_r_tag (TAG_WIDTH); all in.
- stat_clr  in  1  clear counters.
- stat_hit  out  STAT_WIDTH  hit count.
- stat_miss  out  STAT_WIDTH  miss count.

Behaviour:
- Tag RAM read data is valid the cycle after tr_r_ena. The RAM delays writes internally, so a write driven in cycle T is visible to a read issued in cycle T+1 or later.
- Reset values: req_ready=0, resp_valid=0, init_done=0, tr_w_ena=0, tr_r_ena=0, all resp_* = 0, counters = 0.
- Reset at any time, including mid-LOOKUP with a response pending, abandons the operation and re-enters INIT. No response is produced.

States:
- INIT:
  - counter 0..2^IDX_WIDTH-1; each cycle write the line with all we=1 and valid=0, dirty=0, age=0, tag=0.
  - After the last index: init_done=1 (sticky until reset), go to IDLE.
  - Sweep length is exactly 2^IDX_WIDTH cycles.
- IDLE:
  - req_ready=1.
  - On accept with LOOKUP: tr_r_idx=req_idx, tr_r_ena=1; latch op, idx, tag and dirty; go to CMP.
  - FILL: same cycle write valid=1, dirty=req_dirty, age=0, tag=req_tag (all we=1); go to WGAP.
  - INVALIDATE: write valid=0, dirty=0 (valid and dirty we only); go to WGAP.
  - CLEAN: write dirty=0 (dirty we only); go to WGAP.
  - FILL, INVALIDATE and CLEAN produce no response.
- WGAP: one cycle with req_ready=0; then IDLE.
- CMP (one cycle after accept):
  - hit = tr_r_valid & (tr_r_tag == latched tag).
  - Register all resp_* from RAM data and assert resp_valid next cycle.
  - Hit: write age=0; if latched dirty, also dirty=1; age and dirty we only.
  - Miss: write age = min(tr_r_age+1, 2^AGE_WIDTH-1), saturating; age we only.
  - Go to RESP.
- RESP:
  - resp_valid=1; outputs stable while resp_ready=0.
  - On resp_ready: go to IDLE.
  - Minimum LOOKUP turnaround is 3 cycles: accept → resp_valid 2 cycles later → IDLE.
- Unused write-data fields drive 0 and their we=0. tr_r_ena=0 outside the LOOKUP accept cycle.

Optional Feature:
- Macro: MC_TAG_STATS_EN.
- Defined:
  - stat_hit / stat_miss increment in the CMP cycle on hit / miss; each saturates at all-ones.
  - stat_clr forces both to 0 and takes priority over a same-cycle increment.
  - rst clears both.
- Undefined: stat_hit and stat_miss are constant 0, stat_clr is ignored, and no counter logic exists.

Test Plan:
- Reset, IDX_WIDTH=4: init_done rises 16 cycles after INIT entry; sweep writes idx 0..15 with valid=0. LOOKUP idx 5 tag 0x123 → resp_hit=0, resp_valid_line=0, resp_age=0.
- FILL idx 5 tag 0x123 dirty=0, then LOOKUP idx 5 tag 0x123 dirty=1 → resp_hit=1, resp_dirty=0. A second LOOKUP → resp_hit=1, resp_dirty=1, resp_age=0.
- LOOKUP idx 5 tag 0x456 four times → all miss, resp_tag=0x123; resp_age 0,1,2,3, and a fifth LOOKUP returns 3 (saturated).
- Hold resp_ready=0 for 10 cycles → resp_* stable and req_ready=0. Assert rst mid-hold → resp_valid=0 next cycle and INIT restarts.
- FILL idx 7, INVALIDATE idx 7, LOOKUP idx 7 back-to-back → req_ready low for 1 cycle after each write op; LOOKUP returns resp_hit=0, resp_valid_line=0.
- MC_TAG_STATS_EN, STAT_WIDTH=2: 5 hits → stat_hit=3. stat_clr together with a hit → stat_hit=0.

Source files
------------

// File: rtl/mc_tag_ctrl.sv
// Tag RAM client: power-up clear, LOOKUP (accept->resp_valid 2 cycles), FILL/INVALIDATE/CLEAN (1 gap cycle).
// One request in flight; req_ready low until the response is taken. Optional counters under MC_TAG_STATS_EN.
module mc_tag_ctrl #(
  parameter int IDX_WIDTH  = 8,
  parameter int TAG_WIDTH  = 12,
  parameter int AGE_WIDTH  = 2,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [IDX_WIDTH-1:0]  req_idx,
  input  logic [TAG_WIDTH-1:0]  req_tag,
  input  logic                  req_dirty,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_hit,
  output logic                  resp_dirty,
  output logic                  resp_valid_line,
  output logic [TAG_WIDTH-1:0]  resp_tag,
  output logic [AGE_WIDTH-1:0]  resp_age,
  output logic                  init_done,
  output logic [IDX_WIDTH-1:0]  tr_w_idx,
  output logic                  tr_w_ena,
  output logic                  tr_w_valid_we,
  output logic                  tr_w_valid,
  output logic                  tr_w_dirty_we,
  output logic                  tr_w_dirty,
  output logic                  tr_w_age_we,
  output logic [AGE_WIDTH-1:0]  tr_w_age,
  output logic                  tr_w_tag_we,
  output logic [TAG_WIDTH-1:0]  tr_w_tag,
  output logic [IDX_WIDTH-1:0]  tr_r_idx,
  output logic                  tr_r_ena,
  input  logic                  tr_r_valid,
  input  logic                  tr_r_dirty,
  input  logic [AGE_WIDTH-1:0]  tr_r_age,
  input  logic [TAG_WIDTH-1:0]  tr_r_tag,
  input  logic                  stat_clr,
  output logic [STAT_WIDTH-1:0] stat_hit,
  output logic [STAT_WIDTH-1:0] stat_miss
);

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_FILL   = 2'd1;
  localparam logic [1:0] OP_INV    = 2'd2;
  localparam logic [1:0] OP_CLEAN  = 2'd3;

  // S_RST keeps every RAM strobe low while rst is held; the sweep starts the cycle after release.
  typedef enum logic [2:0] {S_RST, S_INIT, S_IDLE, S_CMP, S_RESP, S_WGAP} state_t;

  typedef struct packed {
    logic [IDX_WIDTH-1:0] idx;
    logic [TAG_WIDTH-1:0] tag;
    logic                 dirty;
  } lkp_t;

  state_t               state_q, state_d;
  logic [IDX_WIDTH-1:0] init_cnt_q;
  logic                 init_done_q;
  lkp_t                 lkp_q;
  logic                 cmp_hit;
  logic [AGE_WIDTH-1:0] age_inc;

  assign cmp_hit   = tr_r_valid && (tr_r_tag == lkp_q.tag);
  assign age_inc   = (tr_r_age == '1) ? tr_r_age : tr_r_age + AGE_WIDTH'(1);
  assign init_done = init_done_q;

  always_comb begin
    state_d       = state_q;
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    tr_w_idx      = '0;
    tr_w_ena      = 1'b0;
    tr_w_valid_we = 1'b0;
    tr_w_valid    = 1'b0;
    tr_w_dirty_we = 1'b0;
    tr_w_dirty    = 1'b0;
    tr_w_age_we   = 1'b0;
    tr_w_age      = '0;
    tr_w_tag_we   = 1'b0;
    tr_w_tag      = '0;
    tr_r_idx      = '0;
    tr_r_ena      = 1'b0;
    case (state_q)
      S_RST: state_d = S_INIT;
      S_INIT: begin
        tr_w_ena      = 1'b1;
        tr_w_idx      = init_cnt_q;
        tr_w_valid_we = 1'b1;
        tr_w_dirty_we = 1'b1;
        tr_w_age_we   = 1'b1;
        tr_w_tag_we   = 1'b1;
        if (init_cnt_q == '1) state_d = S_IDLE;
      end
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          case (req_op)
            OP_LOOKUP: begin
              tr_r_ena = 1'b1;
              tr_r_idx = req_idx;
              state_d  = S_CMP;
            end
            OP_FILL: begin
              tr_w_ena      = 1'b1;
              tr_w_idx      = req_idx;
              tr_w_valid_we = 1'b1;
              tr_w_valid    = 1'b1;
              tr_w_dirty_we = 1'b1;
              tr_w_dirty    = req_dirty;
              tr_w_age_we   = 1'b1;
              tr_w_tag_we   = 1'b1;
              tr_w_tag      = req_tag;
              state_d       = S_WGAP;
            end
            OP_INV: begin
              tr_w_ena      = 1'b1;
              tr_w_idx      = req_idx;
              tr_w_valid_we = 1'b1;
              tr_w_dirty_we = 1'b1;
              state_d       = S_WGAP;
            end
            OP_CLEAN: begin
              tr_w_ena      = 1'b1;
              tr_w_idx      = req_idx;
              tr_w_dirty_we = 1'b1;
              state_d       = S_WGAP;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_WGAP: state_d = S_IDLE;
      S_CMP: begin
        // Read-modify-write of the looked-up line: age/dirty only, tag and valid untouched.
        tr_w_ena    = 1'b1;
        tr_w_idx    = lkp_q.idx;
        tr_w_age_we = 1'b1;
        if (cmp_hit) begin
          tr_w_dirty_we = lkp_q.dirty;
          tr_w_dirty    = lkp_q.dirty;
        end else begin
          tr_w_age = age_inc;
        end
        state_d = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_RST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_RST;
      init_cnt_q      <= '0;
      init_done_q     <= 1'b0;
      lkp_q           <= '0;
      resp_hit        <= 1'b0;
      resp_dirty      <= 1'b0;
      resp_valid_line <= 1'b0;
      resp_tag        <= '0;
      resp_age        <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) begin
        init_cnt_q <= init_cnt_q + IDX_WIDTH'(1);
        if (init_cnt_q == '1) init_done_q <= 1'b1;
      end
      if (state_q == S_IDLE && req_valid && req_op == OP_LOOKUP) begin
        lkp_q.idx   <= req_idx;
        lkp_q.tag   <= req_tag;
        lkp_q.dirty <= req_dirty;
      end
      if (state_q == S_CMP) begin
        resp_hit        <= cmp_hit;
        resp_dirty      <= tr_r_dirty;
        resp_valid_line <= tr_r_valid;
        resp_tag        <= tr_r_tag;
        resp_age        <= tr_r_age;
      end
    end
  end

`ifdef MC_TAG_STATS_EN
  logic [STAT_WIDTH-1:0] stat_hit_q, stat_miss_q;

  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      stat_hit_q  <= '0;
      stat_miss_q <= '0;
    end else if (state_q == S_CMP) begin
      if (cmp_hit && stat_hit_q != '1)   stat_hit_q  <= stat_hit_q + STAT_WIDTH'(1);
      if (!cmp_hit && stat_miss_q != '1) stat_miss_q <= stat_miss_q + STAT_WIDTH'(1);
    end
  end

  assign stat_hit  = stat_hit_q;
  assign stat_miss = stat_miss_q;
`else
  logic unused_stat_clr;
  assign unused_stat_clr = stat_clr;
  assign stat_hit        = '0;
  assign stat_miss       = '0;
`endif

endmodule

// File: tb/tb_mc_tag_ctrl.sv
// Directed bench for mc_tag_ctrl with a behavioural tag RAM (1-cycle read, write visible next cycle).
module tb_mc_tag_ctrl;
  localparam int IW = 4;
  localparam int TW = 12;
  localparam int AW = 2;
  localparam int SW = 2;
  localparam int NL = 1 << IW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_dirty;
  logic [1:0]    req_op;
  logic [IW-1:0] req_idx;
  logic [TW-1:0] req_tag;
  logic          resp_valid, resp_ready, resp_hit, resp_dirty, resp_valid_line;
  logic [TW-1:0] resp_tag;
  logic [AW-1:0] resp_age;
  logic          init_done;
  logic [IW-1:0] tr_w_idx, tr_r_idx;
  logic          tr_w_ena, tr_w_valid_we, tr_w_valid, tr_w_dirty_we, tr_w_dirty;
  logic          tr_w_age_we, tr_w_tag_we, tr_r_ena;
  logic [AW-1:0] tr_w_age;
  logic [TW-1:0] tr_w_tag;
  logic          tr_r_valid, tr_r_dirty;
  logic [AW-1:0] tr_r_age;
  logic [TW-1:0] tr_r_tag;
  logic          stat_clr;
  logic [SW-1:0] stat_hit, stat_miss;

  mc_tag_ctrl #(.IDX_WIDTH(IW), .TAG_WIDTH(TW), .AGE_WIDTH(AW), .STAT_WIDTH(SW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_idx(req_idx),
    .req_tag(req_tag), .req_dirty(req_dirty),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_hit(resp_hit),
    .resp_dirty(resp_dirty), .resp_valid_line(resp_valid_line), .resp_tag(resp_tag),
    .resp_age(resp_age), .init_done(init_done),
    .tr_w_idx(tr_w_idx), .tr_w_ena(tr_w_ena), .tr_w_valid_we(tr_w_valid_we),
    .tr_w_valid(tr_w_valid), .tr_w_dirty_we(tr_w_dirty_we), .tr_w_dirty(tr_w_dirty),
    .tr_w_age_we(tr_w_age_we), .tr_w_age(tr_w_age), .tr_w_tag_we(tr_w_tag_we),
    .tr_w_tag(tr_w_tag), .tr_r_idx(tr_r_idx), .tr_r_ena(tr_r_ena),
    .tr_r_valid(tr_r_valid), .tr_r_dirty(tr_r_dirty), .tr_r_age(tr_r_age),
    .tr_r_tag(tr_r_tag), .stat_clr(stat_clr), .stat_hit(stat_hit), .stat_miss(stat_miss)
  );

  always #5 clk = ~clk;

  // Behavioural tag RAM
  logic          m_valid [NL];
  logic          m_dirty [NL];
  logic [AW-1:0] m_age   [NL];
  logic [TW-1:0] m_tag   [NL];

  always @(posedge clk) begin
    if (tr_r_ena) begin
      tr_r_valid <= m_valid[tr_r_idx];
      tr_r_dirty <= m_dirty[tr_r_idx];
      tr_r_age   <= m_age[tr_r_idx];
      tr_r_tag   <= m_tag[tr_r_idx];
    end
    if (tr_w_ena) begin
      if (tr_w_valid_we) m_valid[tr_w_idx] <= tr_w_valid;
      if (tr_w_dirty_we) m_dirty[tr_w_idx] <= tr_w_dirty;
      if (tr_w_age_we)   m_age[tr_w_idx]   <= tr_w_age;
      if (tr_w_tag_we)   m_tag[tr_w_idx]   <= tr_w_tag;
    end
  end

  typedef struct {
    logic [1:0]    op;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;
    logic          dirty;
    logic          e_hit, e_dirty, e_vline;
    logic [TW-1:0] e_tag;
    logic [AW-1:0] e_age;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;
  logic clr_in_cmp = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] op, input logic [IW-1:0] idx, input logic [TW-1:0] tag,
                              input logic d, input logic h, input logic rd, input logic vl,
                              input logic [TW-1:0] rt, input logic [AW-1:0] ag);
    vec_t v;
    v.op = op; v.idx = idx; v.tag = tag; v.dirty = d;
    v.e_hit = h; v.e_dirty = rd; v.e_vline = vl; v.e_tag = rt; v.e_age = ag;
    return v;
  endfunction

  function automatic logic [TW+AW+2:0] exp_resp(input vec_t v);
    return {v.e_hit, v.e_dirty, v.e_vline, v.e_tag, v.e_age};
  endfunction

  function automatic logic [TW+AW+2:0] act_resp();
    return {resp_hit, resp_dirty, resp_valid_line, resp_tag, resp_age};
  endfunction

  // Checks the power-up sweep starting right after rst is released.
  task automatic check_sweep();
    int n = 0;
    while (!tr_w_ena && n < 5) begin @(negedge clk); n++; end
    chk("sweep_start", {31'd0, tr_w_ena}, 32'd1);
    for (int i = 0; i < NL; i++) begin
      chk($sformatf("sweep_%0d", i),
          {13'd0, init_done, req_ready, tr_w_ena, tr_w_valid_we, tr_w_dirty_we, tr_w_age_we, tr_w_tag_we,
           tr_w_valid, tr_w_dirty, tr_w_age, tr_w_tag != 12'd0, tr_w_idx},
          {13'd0, 1'b0, 1'b0, 5'b11111, 1'b0, 1'b0, 2'd0, 1'b0, i[IW-1:0]});
      @(negedge clk);
    end
    chk("init_done_after_sweep", {29'd0, init_done, req_ready, tr_w_ena}, {29'd0, 3'b110});
  endtask

  // Presents one request and checks the accept-cycle RAM strobes and the following gap/CMP cycle.
  task automatic issue(input vec_t v);
    int n = 0;
    logic [5:0] wexp;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = v.op; req_idx = v.idx; req_tag = v.tag; req_dirty = v.dirty;
    #1;
    if (v.op == 2'd0) begin
      chk("lookup_rd_strobe", {26'd0, tr_r_ena, tr_w_ena, tr_r_idx}, {26'd0, 1'b1, 1'b0, v.idx});
    end else begin
      case (v.op)
        2'd1:    wexp = {1'b1, 1'b1, 1'b1, v.dirty, 1'b1, 1'b1};
        2'd2:    wexp = 6'b101000;
        default: wexp = 6'b001000;
      endcase
      chk($sformatf("wr_strobe_op%0d", v.op),
          {20'd0, tr_r_ena, tr_w_ena, tr_w_idx,
           tr_w_valid_we, tr_w_valid, tr_w_dirty_we, tr_w_dirty, tr_w_age_we, tr_w_tag_we},
          {20'd0, 1'b0, 1'b1, v.idx, wexp});
    end
    @(negedge clk);
    req_valid = 1'b0;
    if (clr_in_cmp) stat_clr = 1'b1;
    #1;
    chk("busy_after_accept", {30'd0, req_ready, resp_valid}, 32'd0);
    @(negedge clk);
    stat_clr = 1'b0;
    if (v.op != 2'd0) chk("ready_after_gap", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_op(input vec_t v, input string name);
    issue(v);
    if (v.op == 2'd0) begin
      chk({name, "_valid"}, {30'd0, resp_valid, req_ready}, 32'd2);
      chk({name, "_resp"}, 32'(act_resp()), 32'(exp_resp(v)));
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      chk({name, "_release"}, {30'd0, resp_valid, req_ready}, 32'd1);
    end
  endtask

  vec_t vecs[14];
  vec_t hit5, miss5;

  initial begin
    #400000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_op = '0; req_idx = '0; req_tag = '0; req_dirty = 1'b0;
    resp_ready = 1'b0; stat_clr = 1'b0;

    vecs[0]  = mk(2'd0, 4'd5, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'd0);
    vecs[1]  = mk(2'd1, 4'd5, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'd0);
    vecs[2]  = mk(2'd0, 4'd5, 12'h123, 1'b1, 1'b1, 1'b0, 1'b1, 12'h123, 2'd0);
    vecs[3]  = mk(2'd0, 4'd5, 12'h123, 1'b0, 1'b1, 1'b1, 1'b1, 12'h123, 2'd0);
    vecs[4]  = mk(2'd0, 4'd5, 12'h456, 1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 2'd0);
    vecs[5]  = mk(2'd0, 4'd5, 12'h456, 1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 2'd1);
    vecs[6]  = mk(2'd0, 4'd5, 12'h456, 1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 2'd2);
    vecs[7]  = mk(2'd0, 4'd5, 12'h456, 1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 2'd3);
    vecs[8]  = mk(2'd0, 4'd5, 12'h456, 1'b0, 1'b0, 1'b1, 1'b1, 12'h123, 2'd3);
    vecs[9]  = mk(2'd1, 4'd7, 12'hABC, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 2'd0);
    vecs[10] = mk(2'd2, 4'd7, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'd0);
    vecs[11] = mk(2'd0, 4'd7, 12'hABC, 1'b0, 1'b0, 1'b0, 1'b0, 12'hABC, 2'd0);
    vecs[12] = mk(2'd3, 4'd5, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'd0);
    vecs[13] = mk(2'd0, 4'd5, 12'h123, 1'b0, 1'b1, 1'b0, 1'b1, 12'h123, 2'd3);
    hit5  = mk(2'd0, 4'd5, 12'h123, 1'b0, 1'b1, 1'b0, 1'b1, 12'h123, 2'd0);
    miss5 = mk(2'd0, 4'd5, 12'h123, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 2'd0);

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {22'd0, req_ready, resp_valid, init_done, tr_w_ena, tr_r_ena, resp_hit, resp_dirty,
         resp_valid_line, resp_tag != 12'd0, resp_age != 2'd0},
        32'd0);
    chk("reset_stats", {28'd0, stat_hit, stat_miss}, 32'd0);
    rst = 1'b0;
    check_sweep();

    for (int i = 0; i < 14; i++) do_op(vecs[i], $sformatf("vec%0d", i));

`ifdef MC_TAG_STATS_EN
    chk("stats_saturated", {28'd0, stat_hit, stat_miss}, {28'd0, 2'd3, 2'd3});
`else
    chk("stats_disabled", {28'd0, stat_hit, stat_miss}, 32'd0);
`endif
    stat_clr = 1'b1; @(negedge clk); stat_clr = 1'b0;
    chk("stats_after_clr", {28'd0, stat_hit, stat_miss}, 32'd0);
    for (int i = 0; i < 5; i++) do_op(hit5, $sformatf("hit5_%0d", i));
`ifdef MC_TAG_STATS_EN
    chk("stat_hit_5", {28'd0, stat_hit, stat_miss}, {28'd0, 2'd3, 2'd0});
`else
    chk("stat_hit_5", {28'd0, stat_hit, stat_miss}, 32'd0);
`endif
    clr_in_cmp = 1'b1;
    do_op(hit5, "clr_vs_hit");
    clr_in_cmp = 1'b0;
    chk("stat_clr_priority", {28'd0, stat_hit, stat_miss}, 32'd0);

    // Response held with resp_ready low, then reset while it is pending.
    issue(hit5);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("hold_%0d_hs", i), {30'd0, resp_valid, req_ready}, 32'd2);
      chk($sformatf("hold_%0d_resp", i), 32'(act_resp()), 32'(exp_resp(hit5)));
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_hold", {28'd0, resp_valid, req_ready, init_done, tr_w_ena}, 32'd0);
    rst = 1'b0;
    check_sweep();
    chk("no_resp_after_rst", {31'd0, resp_valid}, 32'd0);
    do_op(miss5, "lookup_after_rst");
    chk("stats_after_rst_lookup", {28'd0, stat_hit, stat_miss},
`ifdef MC_TAG_STATS_EN
        {28'd0, 2'd0, 2'd1});
`else
        32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
